swact_sched: RTL and testbench

SWACT_SCHED -- requirements
Module: swact_sched

---
 rtl/swact_pkg.sv | 19 +
 rtl/swact_eval.sv | 13 +
 rtl/swact_sched.sv | 130 +++++++++++++
 tb/tb_swact_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/swact_pkg.sv
// Shared types and constants for the switching-activity scheduler.
// LFSR vector generation is built only when SWACT_LFSR_EN is defined.
package swact_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LFSR_TAPS = 4'b1100;
  localparam logic [3:0] SEED_NZ   = 4'h1;

  // Fibonacci step for x^4+x^3+1: shift left, feed back v3^v2.
  function automatic logic [3:0] lfsr_step(input logic [3:0] v);
    return {v[2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/swact_eval.sv
// Combinational evaluator: f = (v0 XNOR v1) XNOR (v2 AND v3).
// Pure logic, no state.
module swact_eval (
  input  logic v0_i,
  input  logic v1_i,
  input  logic v2_i,
  input  logic v3_i,
  output logic f_o
);

  assign f_o = ~((~(v0_i ^ v1_i)) ^ (v2_i & v3_i));

endmodule

// File: rtl/swact_sched.sv
// Vector scheduler: FSM, vector generator and ones/toggle counters.
// Define SWACT_LFSR_EN to add LFSR vector mode (mode/lfsr_seed).
module swact_sched
  import swact_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [3:0]       lfsr_seed,
  input  logic [CNT_W-1:0] num_vec,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] toggle_cnt
);

  state_t           state_q, state_d;
  logic [3:0]       vec_q, vec_d;
  logic [3:0]       vec_nxt;
  logic [3:0]       vec_first;
  logic             pf_q, pf_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic             f;
  logic             tog_inc;

  swact_eval u_eval (
    .v0_i (vec_q[0]),
    .v1_i (vec_q[1]),
    .v2_i (vec_q[2]),
    .v3_i (vec_q[3]),
    .f_o  (f)
  );

`ifdef SWACT_LFSR_EN
  logic lfsr_q, lfsr_d;

  assign vec_nxt   = lfsr_q ? lfsr_step(vec_q) : vec_q + 4'd1;
  assign vec_first = !mode ? 4'h0 :
                     (lfsr_seed == 4'h0) ? SEED_NZ : lfsr_seed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 1'b0;
    else        lfsr_q <= lfsr_d;
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == IDLE && start) lfsr_d = mode;
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{mode, lfsr_seed};
  assign vec_nxt    = vec_q + 4'd1;
  assign vec_first  = 4'h0;
`endif

  assign tog_inc = !first_q && (f != pf_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= 4'h0;
      pf_q    <= 1'b0;
      first_q <= 1'b0;
      rem_q   <= '0;
      ones_q  <= '0;
      tog_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pf_q    <= pf_d;
      first_q <= first_d;
      rem_q   <= rem_d;
      ones_q  <= ones_d;
      tog_q   <= tog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    pf_d    = pf_q;
    first_d = first_q;
    rem_d   = rem_q;
    ones_d  = ones_q;
    tog_d   = tog_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ones_d  = '0;
          tog_d   = '0;
          rem_d   = num_vec;
          first_d = 1'b1;
          vec_d   = vec_first;
          state_d = (num_vec == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // abort wins over processing: the vector in this cycle is dropped
        if (abort) begin
          state_d = IDLE;
        end else begin
          ones_d  = ones_q + {{(CNT_W-1){1'b0}}, f};
          tog_d   = tog_q + {{(CNT_W-1){1'b0}}, tog_inc};
          pf_d    = f;
          first_d = 1'b0;
          vec_d   = vec_nxt;
          rem_d   = rem_q - 1'b1;
          if (rem_q == {{(CNT_W-1){1'b0}}, 1'b1}) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign ones_cnt   = ones_q;
  assign toggle_cnt = tog_q;

endmodule

// File: tb/tb_swact_sched.sv
// Scoreboard bench for swact_sched against a behavioural model.
// LFSR cases are exercised when SWACT_LFSR_EN is defined.
module tb_swact_sched;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             mode = 1'b0;
  logic [3:0]       lfsr_seed = 4'h0;
  logic [CNT_W-1:0] num_vec = '0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] ones_cnt;
  logic [CNT_W-1:0] toggle_cnt;

  swact_sched #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .lfsr_seed  (lfsr_seed),
    .num_vec    (num_vec),
    .busy       (busy),
    .done       (done),
    .ones_cnt   (ones_cnt),
    .toggle_cnt (toggle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ones;
    int tog;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   done_seen = 0;
  int   cyc = 0;

`ifdef SWACT_LFSR_EN
  localparam bit LFSR_BUILT = 1'b1;
`else
  localparam bit LFSR_BUILT = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // f from the spec: (v0 == v1) compared for equality against (v2 & v3)
  function automatic int eval_f(input int v);
    int a, b;
    a = ((v & 1) == ((v >> 1) & 1)) ? 1 : 0;
    b = (((v >> 2) & 1) && ((v >> 3) & 1)) ? 1 : 0;
    return (a == b) ? 1 : 0;
  endfunction

  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v >> 3) ^ (v >> 2)) & 1;
    return ((v << 1) & 14) | fb;
  endfunction

  task automatic model(input int n, input bit m, input int seed,
                       output int o, output int t);
    int  v, f, pf;
    bit  use_lfsr;
    use_lfsr = LFSR_BUILT && m;
    v = use_lfsr ? ((seed == 0) ? 1 : seed) : 0;
    o = 0;
    t = 0;
    pf = 0;
    for (int i = 0; i < n; i++) begin
      f = eval_f(v);
      o += f;
      if (i > 0 && f != pf) t++;
      pf = f;
      v = use_lfsr ? lfsr_next(v) : (v + 1) % 16;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_ones", int'(ones_cnt), e.ones);
        chk("sb_toggles", int'(toggle_cnt), e.tog);
        chk("sb_done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic run(input int n, input bit m, input int seed,
                     input bit with_abort, input bit poke,
                     output int o, output int t);
    int k, d0;
    model(n, m, seed, o, t);
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = with_abort;
    num_vec = CNT_W'(n);
    mode = m;
    lfsr_seed = 4'(seed);
    k = cyc;
    d0 = done_seen;
    sb.push_back('{o, t, k + n + 1});
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("busy_cycle1", int'(busy), (n > 0) ? 1 : 0);
    if (poke) begin
      start = 1'b1;
      num_vec = CNT_W'(3);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int i = 0; i < n + 8 && done_seen == d0; i++) @(posedge clk);
    if (done_seen == d0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
    chk("hold_ones", int'(ones_cnt), o);
    chk("hold_toggles", int'(toggle_cnt), t);
  endtask

  initial begin
    int o, t, n;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ones", int'(ones_cnt), 0);
    chk("rst_toggles", int'(toggle_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(16, 0, 0, 0, 0, o, t);
    chk("c16_ones", o, 8);
    chk("c16_toggles", t, 9);
    run(4, 0, 0, 0, 0, o, t);
    chk("c4_ones", o, 2);
    chk("c4_toggles", t, 2);
    run(20, 0, 0, 0, 1, o, t);
    chk("c20_ones", o, 10);
    chk("c20_toggles", t, 12);
    run(0, 0, 0, 0, 0, o, t);
    chk("c0_ones", int'(ones_cnt), 0);
    run(5, 0, 0, 1, 0, o, t);

    // abort in the third RUN cycle: only vectors 0 and 1 are counted
    @(posedge clk);
    #1;
    start = 1'b1;
    num_vec = CNT_W'(16);
    mode = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_ones", int'(ones_cnt), 1);
    chk("abort_toggles", int'(toggle_cnt), 1);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_hold_ones", int'(ones_cnt), 1);

    run(15, 1, 0, 0, 0, o, t);
    if (LFSR_BUILT) chk("lfsr15_ones", o, 8);
    run(1, 1, 0, 0, 0, o, t);
    if (LFSR_BUILT) chk("lfsr_seed0_first", o, 1);
    else            chk("ctr_first", o, 0);

    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(0, 40);
      run(n, 1'($urandom), int'($urandom_range(0, 15)),
          1'($urandom), 1'($urandom), o, t);
    end

    // reset mid-run drops the run; no done must follow
    @(posedge clk);
    #1;
    start = 1'b1;
    num_vec = CNT_W'(16);
    mode = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_ones", int'(ones_cnt), 0);
    chk("midrst_toggles", int'(toggle_cnt), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(16, 0, 0, 0, 0, o, t);
    chk("postrst_ones", int'(ones_cnt), 8);
    chk("postrst_toggles", int'(toggle_cnt), 9);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
